// File: rtl/bcd_counter_multi_if.sv
// Control and status bundle for the multi-digit BCD counter.
// The master drives the count controls; the slave (the counter) returns count and flags.
interface bcd_counter_multi_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count;
    logic                  tc;
    logic                  ovf;
    logic                  err;

    modport master (
        output en, up, load, load_val,
        input  count, tc, ovf, err
    );

    modport slave (
        input  en, up, load, load_val,
        output count, tc, ovf, err
    );
endinterface

// File: rtl/bcd_counter_multi.sv
// Parametrised multi-digit packed-BCD up/down counter with validated parallel load,
// terminal-count flag and wrap/saturate limit handling.
module bcd_counter_multi #(
    parameter int unsigned DIGITS = 4,
    parameter bit          WRAP   = 1'b1
) (
    input logic               clk,
    input logic               reset,
    bcd_counter_multi_if.slave bus
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] count_q;
    logic         ovf_q;
    logic         err_q;

    logic [W-1:0] step_val;
    logic         limit_hit;
    logic         at_max;
    logic         at_min;
    logic         load_ok;

    // Ripple carry (up) or borrow (down) through the digits; a carry out of the top
    // digit means the step crosses MAX->MIN or MIN->MAX.
    always_comb begin
        logic       chain;
        logic [3:0] dig;
        chain    = 1'b1;
        step_val = count_q;
        at_max   = 1'b1;
        at_min   = 1'b1;
        load_ok  = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            dig = count_q[4*i +: 4];
            at_max = at_max & (dig == 4'd9);
            at_min = at_min & (dig == 4'd0);
            load_ok = load_ok & (bus.load_val[4*i +: 4] <= 4'd9);
            if (chain) begin
                if (bus.up) begin
                    if (dig == 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = dig + 4'd1;
                        chain = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                    end else begin
                        step_val[4*i +: 4] = dig - 4'd1;
                        chain = 1'b0;
                    end
                end
            end
        end
        limit_hit = chain;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            err_q <= 1'b0;
            if (bus.load) begin
                if (load_ok) begin
                    count_q <= bus.load_val;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (bus.en) begin
                if (limit_hit) begin
                    ovf_q <= 1'b1;
                    // Saturating mode keeps the limit value and still flags the attempt.
                    if (WRAP) begin
                        count_q <= step_val;
                    end
                end else begin
                    count_q <= step_val;
                end
            end
        end
    end

    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;
    assign bus.err   = err_q;
    assign bus.tc    = bus.up ? at_max : at_min;

endmodule
